mem_arbiter: RTL and testbench

Sits between the split L1 caches (icache, dcache) and the single burst memory port at the mp4 top level. It arbitrates whole-cacheline requests from both caches. Each granted request becomes a 4-beat x 64-bit burst on the memory port. Read data is assembled into a 256-bit line and returned to the requester with a one-cycle resp pulse.

---
 rtl/mem_arbiter_pkg.sv | 13 +
 rtl/mem_arbiter_if.sv | 28 ++
 rtl/mem_arbiter_adaptor.sv | 34 +++
 rtl/mem_arbiter.sv | 58 +++++
 tb/tb_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arb_types: shared constants, FSM state and beat index types for the memory arbiter.
package mem_arb_types;
    localparam int LINE_BITS = 256;
    localparam int BEAT_BITS = 64;
    localparam int BEATS = LINE_BITS / BEAT_BITS;
    localparam int OFFSET_BITS = 5;
    typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, DONE} state_t;
    typedef logic [1:0] beat_t;
    typedef logic [LINE_BITS-1:0] line_t;
    function automatic logic [31:0] line_align(input logic [31:0] a);
        return {a[31:OFFSET_BITS], OFFSET_BITS'(0)};
    endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache request/response and burst memory signals; master is the arbiter side.
interface mem_arbiter_if;
    import mem_arb_types::*;
    logic i_read;
    logic [31:0] i_addr;
    line_t i_rdata;
    logic i_resp;
    logic d_read;
    logic d_write;
    logic [31:0] d_addr;
    line_t d_wdata;
    line_t d_rdata;
    logic d_resp;
    logic mem_read;
    logic mem_write;
    logic [31:0] mem_addr;
    logic [BEAT_BITS-1:0] mem_wdata;
    logic [BEAT_BITS-1:0] mem_rdata;
    logic mem_resp;
    modport master (
        input i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
    );
    modport slave (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
        input i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter_adaptor.sv
// cacheline_adaptor: line buffer and beat counter turning a cacheline into a 4-beat burst and back.
module cacheline_adaptor
    import mem_arb_types::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 active,
    input  logic                 rd,
    input  logic                 mem_resp,
    input  line_t                wdata,
    input  logic [BEAT_BITS-1:0] rdata,
    output line_t                line,
    output logic [BEAT_BITS-1:0] wbeat,
    output logic                 burst_done
);
    beat_t k;
    logic beat;
    always_comb begin
        beat = active && mem_resp;
        burst_done = beat && k == beat_t'(BEATS - 1);
        wbeat = line[BEAT_BITS*k +: BEAT_BITS];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            k <= '0;
            line <= '0;
        end else begin
            if (beat) k <= burst_done ? '0 : k + 1'b1;
            if (load) line <= wdata;
            else if (beat && rd) line[BEAT_BITS*k +: BEAT_BITS] <= rdata;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: fixed-priority arbiter (d_write > d_read > i_read) between L1 caches and the burst memory port.
module mem_arbiter
    import mem_arb_types::*;
(
    input logic clk,
    input logic rst,
    mem_arbiter_if.master bus
);
    state_t state, nxt, grant;
    logic [31:0] addr;
    line_t line, i_line, d_line;
    logic burst, burst_done;
    cacheline_adaptor u_adaptor (
        .clk(clk),
        .rst(rst),
        .load(state == IDLE && bus.d_write),
        .active(burst),
        .rd(state != D_WR),
        .mem_resp(bus.mem_resp),
        .wdata(bus.d_wdata),
        .rdata(bus.mem_rdata),
        .line(line),
        .wbeat(bus.mem_wdata),
        .burst_done(burst_done)
    );
    always_ff @(posedge clk) state <= rst ? IDLE : nxt;
    always_comb begin
        nxt = state == IDLE ? (bus.d_write ? D_WR : bus.d_read ? D_RD : bus.i_read ? I_RD : IDLE)
            : state == DONE ? IDLE
            : burst_done ? DONE : state;
    end
    // Per-port result registers keep each cache's last line stable while the other port fills.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
            grant <= IDLE;
            i_line <= '0;
            d_line <= '0;
        end else begin
            if (state == IDLE && nxt != IDLE) begin
                addr <= line_align((bus.d_write || bus.d_read) ? bus.d_addr : bus.i_addr);
                grant <= nxt;
            end
            if (state == DONE && grant == I_RD) i_line <= line;
            if (state == DONE && grant == D_RD) d_line <= line;
        end
    end
    always_comb begin
        burst = state inside {I_RD, D_RD, D_WR};
        bus.mem_read = state == I_RD || state == D_RD;
        bus.mem_write = state == D_WR;
        bus.mem_addr = addr;
        bus.i_resp = state == DONE && grant == I_RD;
        bus.d_resp = state == DONE && grant != I_RD;
        bus.i_rdata = bus.i_resp ? line : i_line;
        bus.d_rdata = (bus.d_resp && grant == D_RD) ? line : d_line;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench with a behavioural memory responder and cache requesters.
module tb_mem_arbiter;
    import mem_arb_types::*;
    typedef struct {bit w; logic [31:0] a; line_t l;} exp_t;
    typedef struct {int port; bit w; logic [31:0] a; line_t l;} burst_t;
    logic clk = 0;
    logic rst = 1;
    mem_arbiter_if bus();
    mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    exp_t iq[$];
    exp_t dq[$];
    burst_t bq[$];
    line_t last_i = '0;
    bit gap_en = 0;
    bit started = 0;
    int b = 0;
    burst_t cur;
    bit pdw = 0, pdr = 0, pir = 0;

    function automatic logic [63:0] pat(input logic [31:0] a, input int n);
        return {a, 32'hC0DE_0000 | 32'(n)};
    endfunction
    function automatic line_t pat_line(input logic [31:0] a);
        return {pat(a, 3), pat(a, 2), pat(a, 1), pat(a, 0)};
    endfunction
    function automatic line_t rand_line();
        line_t l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction
    task automatic chk(input string n, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", n, act, exp);
        end
    endtask

    // Memory: the data of beat n at line address a is pat(a, n); writes are captured per beat.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            started = 0;
            b = 0;
            bus.mem_resp = 0;
        end else if (bus.mem_read || bus.mem_write) begin
            if (!started) begin
                started = 1;
                b = 0;
                cur.port = (pdw || pdr) ? 1 : 0;
                cur.w = pdw;
                cur.a = bus.mem_addr;
                cur.l = '0;
                chk("grant_write", bus.mem_write, pdw);
                chk("grant_read", bus.mem_read, !pdw && (pdr || pir));
            end
            chk("addr_hold", bus.mem_addr, cur.a);
            if (!gap_en || $urandom_range(2) != 0) begin
                bus.mem_resp = 1;
                bus.mem_rdata = pat(cur.a, b);
                cur.l[64*b +: 64] = bus.mem_wdata;
                b++;
                if (b == 4) begin
                    bq.push_back(cur);
                    started = 0;
                end
            end else bus.mem_resp = 0;
        end else begin
            if (started) begin
                chk("burst_held", bus.mem_read | bus.mem_write, 1);
                started = 0;
            end
            bus.mem_resp = 1'($urandom_range(1));
            bus.mem_rdata = {$urandom, $urandom};
        end
        pdw = bus.d_write;
        pdr = bus.d_read;
        pir = bus.i_read;
    end

    initial forever begin
        exp_t e;
        burst_t r;
        @(negedge clk);
        if (!rst && bus.i_resp) begin
            if (iq.size() == 0 || bq.size() == 0) chk("i_resp_unexpected", bus.i_resp, 0);
            else begin
                e = iq.pop_front();
                r = bq.pop_front();
                chk("i_port", r.port, 0);
                chk("i_addr", r.a, e.a);
                chk("i_kind", r.w, 0);
                chk("i_rdata", bus.i_rdata, e.l);
                last_i = e.l;
            end
        end
        if (!rst && bus.d_resp) begin
            if (dq.size() == 0 || bq.size() == 0) chk("d_resp_unexpected", bus.d_resp, 0);
            else begin
                e = dq.pop_front();
                r = bq.pop_front();
                chk("d_port", r.port, 1);
                chk("d_addr", r.a, e.a);
                chk("d_kind", r.w, e.w);
                if (e.w) chk("d_wdata", r.l, e.l);
                else chk("d_rdata", bus.d_rdata, e.l);
                chk("i_rdata_hold", bus.i_rdata, last_i);
            end
        end
    end

    task automatic i_txn(input logic [31:0] a, input bit scr, output int lat);
        bus.i_addr = a;
        bus.i_read = 1;
        iq.push_back('{1'b0, line_align(a), pat_line(line_align(a))});
        lat = -1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (scr && c == 2) bus.i_addr = ~a;
            if (bus.i_resp) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) chk("i_timeout", 0, 1);
        @(posedge clk);
        #1 bus.i_read = 0;
        bus.i_addr = $urandom;
    endtask

    task automatic d_txn(input bit w, input bit both, input logic [31:0] a, input bit scr);
        line_t wd = rand_line();
        bit got = 0;
        bus.d_addr = a;
        bus.d_write = w;
        bus.d_read = !w || both;
        bus.d_wdata = wd;
        dq.push_back('{w, line_align(a), w ? wd : pat_line(line_align(a))});
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (scr && c == 2) begin
                bus.d_addr = ~a;
                bus.d_wdata = ~wd;
            end
            if (bus.d_resp) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("d_timeout", 0, 1);
        @(posedge clk);
        #1 bus.d_read = 0;
        bus.d_write = 0;
        bus.d_addr = $urandom;
        bus.d_wdata = rand_line();
    endtask

    initial begin
        int lat;
        bus.i_read = 0;
        bus.i_addr = '0;
        bus.d_read = 0;
        bus.d_write = 0;
        bus.d_addr = '0;
        bus.d_wdata = '0;
        bus.mem_resp = 0;
        bus.mem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_read", bus.mem_read, 0);
        chk("rst_mem_write", bus.mem_write, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_resp", {bus.i_resp, bus.d_resp}, 0);
        chk("rst_i_rdata", bus.i_rdata, 0);
        chk("rst_d_rdata", bus.d_rdata, 0);
        @(posedge clk);
        #1 rst = 0;
        i_txn(32'h0000_0064, 1, lat);
        chk("latency", lat, 5);
        d_txn(1, 0, 32'h8000_1FFF, 1);
        fork
            i_txn($urandom, 0, lat);
            d_txn(0, 0, $urandom, 0);
        join
        d_txn(1, 1, $urandom, 0);
        gap_en = 1;
        i_txn($urandom, 0, lat);
        fork
            repeat (25) begin
                repeat ($urandom_range(3)) begin
                    @(posedge clk);
                    #1;
                end
                i_txn($urandom, 0, lat);
            end
            repeat (25) begin
                repeat ($urandom_range(3)) begin
                    @(posedge clk);
                    #1;
                end
                d_txn(1'($urandom_range(1)), $urandom_range(3) == 0, $urandom, 0);
            end
        join
        bus.i_addr = $urandom;
        bus.i_read = 1;
        lat = -1;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            if (started && b >= 2) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) chk("rst_burst_timeout", 0, 1);
        #1 rst = 1;
        bus.i_read = 0;
        @(posedge clk);
        #1 rst = 0;
        last_i = '0;
        @(negedge clk);
        chk("rst_burst_read", bus.mem_read, 0);
        chk("rst_burst_resp", bus.i_resp, 0);
        chk("rst_burst_i_rdata", bus.i_rdata, 0);
        @(negedge clk);
        chk("rst_idle_read", bus.mem_read, 0);
        @(posedge clk);
        #1 i_txn($urandom, 0, lat);
        repeat (3) @(posedge clk);
        chk("queues_drained", iq.size() + dq.size() + bq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
